// File: rtl/wb_stage.sv
// Write-back stage: registers the EX/MEM result, extracts load data, and shares the
// single RF write port with a 2-entry mul/div result queue. Optional macro: WB_LDX_EN.
module wb_stage #(
    parameter int MDQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        mem_we_i,
    input  logic [4:0]  mem_addr_i,
    input  logic [31:0] mem_alu_i,
    input  logic [31:0] mem_dout_i,
    input  logic [2:0]  mem_ld_ctl_i,
    input  logic [1:0]  mem_badr_i,
    input  logic        cls_i,
    input  logic        clr_i,
    input  logic        md_valid_i,
    input  logic [4:0]  md_addr_i,
    input  logic [31:0] md_data_i,
    output logic        md_ready_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_din_o,
    output logic [31:0] fw_mem_o,
    output logic        md_pend_o
);

    localparam int PW = 1;

    typedef struct packed {
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] data;
    } mdq_ent_t;

    // ---------------- load extraction ----------------
    logic [31:0] ld_data;

`ifdef WB_LDX_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // big-endian lane select: badr 0 is the most significant byte
        case (mem_badr_i)
            2'd0:    ld_byte = mem_dout_i[31:24];
            2'd1:    ld_byte = mem_dout_i[23:16];
            2'd2:    ld_byte = mem_dout_i[15:8];
            default: ld_byte = mem_dout_i[7:0];
        endcase
        ld_half = mem_badr_i[1] ? mem_dout_i[15:0] : mem_dout_i[31:16];
    end

    always_comb begin
        ld_data = mem_alu_i;
        case (mem_ld_ctl_i)
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {24'd0, ld_byte};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'd0, ld_half};
            3'd5:    ld_data = mem_dout_i;
            default: ld_data = mem_alu_i;
        endcase
    end
`else
    logic unused_badr;
    assign unused_badr = ^mem_badr_i;

    always_comb begin
        ld_data = mem_alu_i;
        case (mem_ld_ctl_i)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: ld_data = mem_dout_i;
            default:                      ld_data = mem_alu_i;
        endcase
    end
`endif

    // ---------------- stage register ----------------
    logic        st_we_q,   st_we_d;
    logic [4:0]  st_addr_q, st_addr_d;
    logic [31:0] st_data_q, st_data_d;
    logic        done_q,    done_d;
    logic        pipe_vld;

    assign pipe_vld = st_we_q && (st_addr_q != 5'd0) && !done_q;

    always_comb begin
        st_we_d   = st_we_q;
        st_addr_d = st_addr_q;
        st_data_d = st_data_q;
        done_d    = done_q;
        if (clr_i) begin
            st_we_d   = 1'b0;
            st_addr_d = 5'd0;
            st_data_d = 32'd0;
            done_d    = 1'b0;
        end else if (cls_i) begin
            // a held instruction writes back once; later stall cycles free the port
            done_d = done_q | pipe_vld;
        end else begin
            st_we_d   = mem_we_i;
            st_addr_d = mem_addr_i;
            st_data_d = ld_data;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            st_we_q   <= 1'b0;
            st_addr_q <= 5'd0;
            st_data_q <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            st_we_q   <= st_we_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            done_q    <= done_d;
        end
    end

    assign fw_mem_o = st_data_q;

    // ---------------- mul/div result queue ----------------
    mdq_ent_t          mdq_q [MDQ_DEPTH];
    mdq_ent_t          mdq_d [MDQ_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]       cnt_q,    cnt_d;
    mdq_ent_t          head;
    logic              push, pop, head_wr;

    assign md_ready_o = (cnt_q != (PW+1)'(MDQ_DEPTH));
    assign md_pend_o  = (cnt_q != '0);
    assign push       = md_valid_i && md_ready_o;
    assign pop        = !pipe_vld && md_pend_o;
    assign head       = mdq_q[rd_ptr_q];
    // invalidated or r0 entries are still popped, just without a write
    assign head_wr    = pop && head.vld && (head.addr != 5'd0);

    always_comb begin
        for (int i = 0; i < MDQ_DEPTH; i++) begin
            mdq_d[i] = mdq_q[i];
            // younger pipeline write to the same register supersedes queued results
            if (pipe_vld && mdq_q[i].vld && (mdq_q[i].addr == st_addr_q))
                mdq_d[i].vld = 1'b0;
        end
        if (pop)
            mdq_d[rd_ptr_q].vld = 1'b0;
        if (push)
            mdq_d[wr_ptr_q] = '{vld: 1'b1, addr: md_addr_i, data: md_data_i};

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < MDQ_DEPTH; i++)
                mdq_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < MDQ_DEPTH; i++)
                mdq_q[i] <= mdq_d[i];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ---------------- write-port arbitration ----------------
    logic [4:0]  last_addr_q;
    logic [31:0] last_din_q;

    always_comb begin
        wb_we_o   = 1'b0;
        wb_addr_o = last_addr_q;
        wb_din_o  = last_din_q;
        if (pipe_vld) begin
            wb_we_o   = 1'b1;
            wb_addr_o = st_addr_q;
            wb_din_o  = st_data_q;
        end else if (head_wr) begin
            wb_we_o   = 1'b1;
            wb_addr_o = head.addr;
            wb_din_o  = head.data;
        end
    end

    // idle cycles keep presenting the last written index/data
    always_ff @(posedge clk) begin
        if (rst_i) begin
            last_addr_q <= 5'd0;
            last_din_q  <= 32'd0;
        end else if (wb_we_o) begin
            last_addr_q <= wb_addr_o;
            last_din_q  <= wb_din_o;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load extraction, r0 suppression, queue arbitration,
// WAW invalidation, stall/flush behaviour and reset mid-operation.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_we_i;
    logic [4:0]  mem_addr_i;
    logic [31:0] mem_alu_i;
    logic [31:0] mem_dout_i;
    logic [2:0]  mem_ld_ctl_i;
    logic [1:0]  mem_badr_i;
    logic        cls_i;
    logic        clr_i;
    logic        md_valid_i;
    logic [4:0]  md_addr_i;
    logic [31:0] md_data_i;
    logic        md_ready_o;
    logic        wb_we_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_din_o;
    logic [31:0] fw_mem_o;
    logic        md_pend_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_alu_i   (mem_alu_i),
        .mem_dout_i  (mem_dout_i),
        .mem_ld_ctl_i(mem_ld_ctl_i),
        .mem_badr_i  (mem_badr_i),
        .cls_i       (cls_i),
        .clr_i       (clr_i),
        .md_valid_i  (md_valid_i),
        .md_addr_i   (md_addr_i),
        .md_data_i   (md_data_i),
        .md_ready_o  (md_ready_o),
        .wb_we_o     (wb_we_o),
        .wb_addr_o   (wb_addr_o),
        .wb_din_o    (wb_din_o),
        .fw_mem_o    (fw_mem_o),
        .md_pend_o   (md_pend_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] din);
        chk({tag, ".we"},   {31'd0, wb_we_o}, {31'd0, we});
        chk({tag, ".addr"}, {27'd0, wb_addr_o}, {27'd0, addr});
        chk({tag, ".din"},  wb_din_o, din);
    endtask

    localparam logic [31:0] DW = 32'h80FF_7F01;
`ifdef WB_LDX_EN
    localparam logic [31:0] EXP_LB  = 32'hFFFF_FF80;
    localparam logic [31:0] EXP_LBU = 32'h0000_0080;
    localparam logic [31:0] EXP_LH  = 32'h0000_7F01;
    localparam logic [31:0] EXP_LHU = 32'h0000_80FF;
    localparam logic [31:0] EXP_LB3 = 32'h0000_0001;
`else
    localparam logic [31:0] EXP_LB  = DW;
    localparam logic [31:0] EXP_LBU = DW;
    localparam logic [31:0] EXP_LH  = DW;
    localparam logic [31:0] EXP_LHU = DW;
    localparam logic [31:0] EXP_LB3 = DW;
`endif

    initial begin
        rst_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = '0; mem_alu_i = '0; mem_dout_i = '0;
        mem_ld_ctl_i = '0; mem_badr_i = '0; cls_i = 1'b0; clr_i = 1'b0;
        md_valid_i = 1'b0; md_addr_i = '0; md_data_i = '0;
        tick(); tick();
        chk_wb("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.fw", fw_mem_o, 32'd0);
        chk("reset.pend", {31'd0, md_pend_o}, 32'd0);
        chk("reset.ready", {31'd0, md_ready_o}, 32'd1);
        rst_i = 1'b0;

        // ALU pass-through, one cycle latency
        mem_we_i = 1'b1; mem_addr_i = 5'd5; mem_alu_i = 32'h1234_5678; mem_ld_ctl_i = 3'd0;
        tick();
        chk_wb("alu", 1'b1, 5'd5, 32'h1234_5678);
        chk("alu.fw", fw_mem_o, 32'h1234_5678);

        // load extraction
        mem_addr_i = 5'd6; mem_alu_i = 32'h0; mem_dout_i = DW;
        mem_ld_ctl_i = 3'd1; mem_badr_i = 2'd0; tick();
        chk_wb("lb0", 1'b1, 5'd6, EXP_LB);
        mem_ld_ctl_i = 3'd2; mem_badr_i = 2'd0; tick();
        chk("lbu0", wb_din_o, EXP_LBU);
        mem_ld_ctl_i = 3'd3; mem_badr_i = 2'd2; tick();
        chk("lh2", wb_din_o, EXP_LH);
        mem_ld_ctl_i = 3'd4; mem_badr_i = 2'd0; tick();
        chk("lhu0", wb_din_o, EXP_LHU);
        mem_ld_ctl_i = 3'd1; mem_badr_i = 2'd3; tick();
        chk("lb3", wb_din_o, EXP_LB3);
        mem_ld_ctl_i = 3'd5; mem_badr_i = 2'd1; tick();
        chk("lw", wb_din_o, DW);
        mem_ld_ctl_i = 3'd6; mem_alu_i = 32'hCAFE_0006; tick();
        chk("ctl6", wb_din_o, 32'hCAFE_0006);

        // r0 write suppressed
        mem_ld_ctl_i = 3'd0; mem_addr_i = 5'd0; mem_alu_i = 32'hDEAD_BEEF; tick();
        chk("r0.we", {31'd0, wb_we_o}, 32'd0);
        chk("r0.fw", fw_mem_o, 32'hDEAD_BEEF);
        mem_we_i = 1'b0; tick();

        // pipeline busy while two mul/div results queue up
        mem_we_i = 1'b1; mem_addr_i = 5'd3; mem_alu_i = 32'h3;
        md_valid_i = 1'b1; md_addr_i = 5'd7; md_data_i = 32'hAAAA; tick();
        chk("q1.ready", {31'd0, md_ready_o}, 32'd1);
        chk_wb("q1.wb", 1'b1, 5'd3, 32'h3);
        md_addr_i = 5'd8; md_data_i = 32'hBBBB; tick();
        chk("q2.ready", {31'd0, md_ready_o}, 32'd0);
        chk("q2.pend", {31'd0, md_pend_o}, 32'd1);
        md_valid_i = 1'b0; mem_we_i = 1'b0; tick();
        chk_wb("pop.r7", 1'b1, 5'd7, 32'hAAAA);
        tick();
        chk_wb("pop.r8", 1'b1, 5'd8, 32'hBBBB);
        tick();
        chk_wb("idle.hold", 1'b0, 5'd8, 32'hBBBB);
        chk("idle.ready", {31'd0, md_ready_o}, 32'd1);
        chk("idle.pend", {31'd0, md_pend_o}, 32'd0);

        // WAW: younger pipeline write to r9 kills the queued r9
        mem_we_i = 1'b1; mem_addr_i = 5'd3; mem_alu_i = 32'h3;
        md_valid_i = 1'b1; md_addr_i = 5'd9; md_data_i = 32'h11; tick();
        md_valid_i = 1'b0; mem_addr_i = 5'd9; mem_alu_i = 32'h22; tick();
        chk_wb("waw.pipe", 1'b1, 5'd9, 32'h22);
        mem_we_i = 1'b0; tick();
        chk_wb("waw.drop", 1'b0, 5'd9, 32'h22);
        tick();
        chk("waw.pend", {31'd0, md_pend_o}, 32'd0);
        chk("waw.we", {31'd0, wb_we_o}, 32'd0);

        // stall: held write issued once, queue uses the freed slot, flush gives bubble
        mem_we_i = 1'b1; mem_addr_i = 5'd4; mem_alu_i = 32'h44;
        md_valid_i = 1'b1; md_addr_i = 5'd6; md_data_i = 32'h66; tick();
        chk_wb("cls.c1", 1'b1, 5'd4, 32'h44);
        cls_i = 1'b1; md_valid_i = 1'b0; mem_addr_i = 5'd12; mem_alu_i = 32'hBAD; tick();
        chk_wb("cls.c2", 1'b1, 5'd6, 32'h66);
        chk("cls.fw", fw_mem_o, 32'h44);
        tick();
        chk("cls.c3.we", {31'd0, wb_we_o}, 32'd0);
        clr_i = 1'b1; tick();
        chk("clr.we", {31'd0, wb_we_o}, 32'd0);
        chk("clr.fw", fw_mem_o, 32'd0);
        clr_i = 1'b0; cls_i = 1'b0; mem_addr_i = 5'd10; mem_alu_i = 32'hA; tick();
        chk_wb("resume", 1'b1, 5'd10, 32'hA);

        // reset mid-operation discards queued entries
        mem_addr_i = 5'd3; mem_alu_i = 32'h3;
        md_valid_i = 1'b1; md_addr_i = 5'd11; md_data_i = 32'h1111; tick();
        md_addr_i = 5'd12; md_data_i = 32'h2222; tick();
        chk("pre_rst.pend", {31'd0, md_pend_o}, 32'd1);
        rst_i = 1'b1; md_valid_i = 1'b0; mem_we_i = 1'b0; tick();
        chk_wb("midrst", 1'b0, 5'd0, 32'd0);
        chk("midrst.pend", {31'd0, md_pend_o}, 32'd0);
        chk("midrst.ready", {31'd0, md_ready_o}, 32'd1);
        rst_i = 1'b0; tick();
        chk("postrst.we", {31'd0, wb_we_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the register-file write port. Drives the wb_we / wb_addr / wb_din inputs of the RF stage, and the fw_mem forwarding input of the RF stage.
- Registers the EX/MEM result, performs load-data extraction (byte/halfword select, sign/zero extension), and suppresses writes to r0.
- Arbitrates the single RF write port between the main pipeline and an asynchronous mul/div result port, which is buffered in a 2-entry queue.

Parameters:
- MDQ_DEPTH, 2, mul/div result queue depth; fixed at 2, pointer width 1 bit.

Ports:
- clk  in  1  system clock, rising edge
- rst_i  in  1  synchronous active-high reset
- mem_we_i  in  1  pipeline instruction writes a register
- mem_addr_i  in  5  destination register index
- mem_alu_i  in  32  ALU/address result
- mem_dout_i  in  32  raw data-memory read word
- mem_ld_ctl_i  in  3  0=ALU result, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6-7 treated as 0
- mem_badr_i  in  2  byte address low bits of the load
- cls_i  in  1  stall: hold stage register
- clr_i  in  1  flush: load bubble (priority over cls_i)
- md_valid_i  in  1  mul/div result valid
- md_addr_i  in  5  mul/div destination register
- md_data_i  in  32  mul/div result
- md_ready_o  out  1  queue can accept (count < 2)
- wb_we_o  out  1  RF write enable
- wb_addr_o  out  5  RF write index
- wb_din_o  out  32  RF write data
- fw_mem_o  out  32  forwarding value, equals the stage-register data
- md_pend_o  out  1  queue non-empty (hazard hint to the control FSM)

Behaviour:
- Reset (rst_i=1 at a clk edge):
  - Stage register cleared; wb_we_o=0, wb_addr_o=0, wb_din_o=0, fw_mem_o=0.
  - Queue emptied; md_pend_o=0, md_ready_o=1.
  - Reset mid-operation discards all queued entries.
- Stage register: loads the inputs each edge when clr_i=0 and cls_i=0. Latency is 1 cycle from mem_* to the pipeline write slot.
- Load extraction is performed before registering. Big-endian: badr 0 selects bits 31:24, badr 3 selects bits 7:0.
  - LH uses badr[1]: 0 selects 31:16, 1 selects 15:0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - ld_ctl 0 passes mem_alu_i through.
- clr_i: stage loads a bubble (we=0, addr=0, data=0).
- cls_i: stage holds its contents. A "done" flag is set after the first write-back cycle so the held write is issued once only. Further stall cycles present a free slot.
- Pipeline slot valid = stage we & addr!=0 & !done.
- Port arbitration:
  - A valid pipeline slot always wins: wb_* = stage contents.
  - Otherwise, if the queue is non-empty: wb_* = queue head, and the head is popped the same edge.
  - Otherwise wb_we_o=0, with addr/data holding their last values.
- wb_we_o is never 1 with wb_addr_o=0. Queue entries with addr 0 are accepted and dropped on pop without writing.
- Queue:
  - Push when md_valid_i & md_ready_o.
  - Push and pop in the same cycle keeps count unchanged; with count=2, push is blocked by md_ready_o=0.
  - md_ready_o and md_pend_o are decoded from registered count (no combinational path from md_valid_i).
- WAW ordering: when a valid pipeline write targets index N, any queued entry with addr N is invalidated (the pipeline result is younger). A same-cycle push to N is still enqueued.

Optional Feature:
- Macro: WB_LDX_EN.
- Defined: full LB/LBU/LH/LHU extraction as above.
- Undefined: extraction logic omitted; ld_ctl 1-5 all behave as LW, and mem_badr_i is ignored.

Test Plan:
- Reset, then mem_we_i=1, addr=5, ld_ctl=0, alu=0x1234_5678 → next cycle wb_we_o=1, wb_addr_o=5, wb_din_o=0x1234_5678, fw_mem_o equal.
- LB with dout=0x80FF_7F01: badr=0 → 0xFFFF_FF80; LBU with badr=0 → 0x0000_0080; LH with badr=2 → 0x0000_7F01; under !WB_LDX_EN the same LB → 0x80FF_7F01.
- mem_we_i=1, addr=0 → wb_we_o stays 0.
- Pipeline writing r3 every cycle while md pushes r7=0xAAAA then r8=0xBBBB → md_ready_o=0 after 2 pushes; 1 cycle after the first bubble r7 is written, 1 cycle later r8 is written, then md_ready_o=1.
- Queue holds r9=0x11; pipeline then writes r9=0x22 → r9 written once with 0x22; queue entry dropped; md_pend_o=0.
- cls_i held 3 cycles with stage r4=0x44 and one queued r6 → r4 written on cycle 1 only; r6 written on cycle 2; clr_i during the stall → bubble, no write.
